serial_add_sub: RTL and testbench

//   Bit-serial N-bit adder/subtractor. Operands are processed LSB-first, one bit per clock,

---
 rtl/serial_add_sub_pkg.sv | 15 +
 rtl/serial_add_sub_fa_cell.sv | 22 ++
 rtl/serial_add_sub.sv | 114 +++++++++++
 tb/tb_serial_add_sub.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
//   state_e : FSM state encoding (idle, shifting, done)
//   ModeAdd / ModeSub : values of the mode input
package serial_add_sub_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  localparam logic ModeAdd = 1'b0;
  localparam logic ModeSub = 1'b1;

endpackage

// File: rtl/serial_add_sub_fa_cell.sv
// 1-bit full adder built from two half adders plus an OR.
//   a_i, b_i : operand bits
//   cin_i    : carry in
//   sum_o    : a ^ b ^ cin
//   cout_o   : majority(a, b, cin)
module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  logic ha0_sum, ha0_carry, ha1_carry;

  assign ha0_sum   = a_i ^ b_i;
  assign ha0_carry = a_i & b_i;
  assign sum_o     = ha0_sum ^ cin_i;
  assign ha1_carry = ha0_sum & cin_i;
  assign cout_o    = ha0_carry | ha1_carry;

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial N-bit adder/subtractor, LSB first, one bit per clock through a single
// full-adder cell and a registered carry/borrow.
//   clk_i    : rising-edge clock
//   rst_i    : asynchronous active-high reset
//   start_i  : request, sampled in idle or done only
//   mode_i   : 0 = a + b, 1 = a - b (latched with start)
//   a_i, b_i : operands (latched with start)
//   result_o : sum/difference, valid on done and held afterwards in idle
//   cout_o   : carry out (subtract: 1 = no borrow)
//   ovf_o    : two's-complement overflow
//   busy_o   : high while shifting
//   done_o   : one-cycle pulse when result/flags are valid
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         mode_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] result_o,
  output logic         cout_o,
  output logic         ovf_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam int unsigned CntW = $clog2(N);
  localparam logic [CntW-1:0] LastBit = CntW'(N - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic [N-1:0]    a_q, a_d, b_q, b_d, res_q, res_d;
  logic            carry_q, carry_d;
  logic            cmsb_q, cmsb_d;
  logic            fa_sum, fa_carry;

  fa_cell u_fa_cell (
    .a_i   (a_q[0]),
    .b_i   (b_q[0]),
    .cin_i (carry_q),
    .sum_o (fa_sum),
    .cout_o(fa_carry)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cmsb_d  = cmsb_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
          a_d     = a_i;
          b_d     = b_i ^ {N{mode_i}};
          carry_d = (mode_i == ModeSub);
          count_d = '0;
          state_d = StShift;
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = {fa_sum, res_q[N-1:1]};
        carry_d = fa_carry;
        count_d = count_q + CntW'(1);
        if (count_q == LastBit) begin
          // Carry into the MSB, needed for the overflow flag.
          cmsb_d  = carry_q;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      count_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cmsb_q  <= cmsb_d;
    end
  end

  // The carry register holds the final carry from done until the next accepted start.
  assign result_o = res_q;
  assign cout_o   = carry_q;
  assign ovf_o    = cmsb_q ^ carry_q;
  assign busy_o   = (state_q == StShift);
  assign done_o   = (state_q == StDone);

endmodule

// File: tb/tb_serial_add_sub.sv
module tb_serial_add_sub;

  localparam int unsigned N = 8;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic         mode_i;
  logic [N-1:0] a_i, b_i;
  logic [N-1:0] result_o;
  logic         cout_o, ovf_o, busy_o, done_o;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk_i = ~clk_i;

  serial_add_sub #(.N(N)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .mode_i  (mode_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .result_o(result_o),
    .cout_o  (cout_o),
    .ovf_o   (ovf_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic. Returns {ovf, cout, result}.
  function automatic logic [N+1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic m);
    int full, sa, sb, sr, exact;
    logic [N-1:0] r;
    logic c, o;
    if (m) full = int'(a) + (2 ** N) - int'(b);
    else   full = int'(a) + int'(b);
    r  = N'(full % (2 ** N));
    c  = (full >= 2 ** N);
    sa = a[N-1] ? int'(a) - 2 ** N : int'(a);
    sb = b[N-1] ? int'(b) - 2 ** N : int'(b);
    sr = r[N-1] ? int'(r) - 2 ** N : int'(r);
    exact = m ? sa - sb : sa + sb;
    o  = (exact != sr);
    return {o, c, r};
  endfunction

  // Drive a request across one sampling edge, then scramble the inputs.
  task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b, input logic m);
    a_i = a; b_i = b; mode_i = m; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    a_i = N'($urandom); b_i = N'($urandom); mode_i = 1'($urandom);
  endtask

  // Called one step after the sampling edge; waits for done and checks everything.
  task automatic wait_check(input logic [N-1:0] a, input logic [N-1:0] b, input logic m,
                            input string tag);
    logic [N+1:0] e;
    int edges;
    e = model(a, b, m);
    edges = 1;
    while (done_o !== 1'b1 && edges < 4 * N) begin
      chk({tag, "/busy"}, 32'(busy_o), 32'd1);
      tick();
      edges++;
    end
    chk({tag, "/done"}, 32'(done_o), 32'd1);
    chk({tag, "/latency"}, edges, N + 1);
    chk({tag, "/result"}, 32'(result_o), 32'(e[N-1:0]));
    chk({tag, "/cout"}, 32'(cout_o), 32'(e[N]));
    chk({tag, "/ovf"}, 32'(ovf_o), 32'(e[N+1]));
    chk({tag, "/busy_done"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    logic [N-1:0] ra, rb, held;
    logic rm;
    int pulses;

    rst_i = 1'b1; start_i = 1'b0; mode_i = 1'b0; a_i = '0; b_i = '0;
    tick();
    tick();
    chk("reset/result", 32'(result_o), 32'd0);
    chk("reset/cout", 32'(cout_o), 32'd0);
    chk("reset/ovf", 32'(ovf_o), 32'd0);
    chk("reset/busy", 32'(busy_o), 32'd0);
    chk("reset/done", 32'(done_o), 32'd0);
    rst_i = 1'b0;
    tick();

    // Basic add, latency and pulse width.
    launch(8'h35, 8'h4A, 1'b0);
    wait_check(8'h35, 8'h4A, 1'b0, "add35_4a");
    chk("add35_4a/result_lit", 32'(result_o), 32'h7F);
    tick();
    chk("add35_4a/width", 32'(done_o), 32'd0);
    chk("add35_4a/hold", 32'(result_o), 32'h7F);

    launch(8'hFF, 8'h01, 1'b0); wait_check(8'hFF, 8'h01, 1'b0, "addff_01"); tick();
    launch(8'h7F, 8'h01, 1'b0); wait_check(8'h7F, 8'h01, 1'b0, "add7f_01"); tick();
    launch(8'h32, 8'h1E, 1'b1); wait_check(8'h32, 8'h1E, 1'b1, "sub32_1e"); tick();
    launch(8'h10, 8'h20, 1'b1); wait_check(8'h10, 8'h20, 1'b1, "sub10_20"); tick();
    launch(8'h80, 8'h01, 1'b1); wait_check(8'h80, 8'h01, 1'b1, "sub80_01");
    chk("sub80_01/ovf_lit", 32'(ovf_o), 32'd1);
    tick();

    // Start during shift is ignored.
    launch(8'h21, 8'h13, 1'b0);
    pulses = 0;
    held = '0;
    for (int i = 1; i <= 2 * N; i++) begin
      if (i == 3) begin a_i = 8'hC3; b_i = 8'h5A; mode_i = 1'b1; start_i = 1'b1; end
      if (i == 4) start_i = 1'b0;
      tick();
      if (done_o === 1'b1) begin pulses++; held = result_o; end
    end
    chk("ignore/pulses", pulses, 1);
    chk("ignore/result", 32'(held), 32'h34);
    chk("ignore/busy_end", 32'(busy_o), 32'd0);

    // Asynchronous reset mid-shift.
    launch(8'h5A, 8'h33, 1'b0);
    tick(); tick(); tick();
    #2 rst_i = 1'b1;
    #1;
    chk("abort/result", 32'(result_o), 32'd0);
    chk("abort/cout", 32'(cout_o), 32'd0);
    chk("abort/ovf", 32'(ovf_o), 32'd0);
    chk("abort/busy", 32'(busy_o), 32'd0);
    chk("abort/done", 32'(done_o), 32'd0);
    tick();
    rst_i = 1'b0;
    pulses = 0;
    for (int i = 0; i < 2 * N; i++) begin
      tick();
      if (done_o === 1'b1) pulses++;
    end
    chk("abort/no_done", pulses, 0);
    launch(8'h01, 8'h01, 1'b0); wait_check(8'h01, 8'h01, 1'b0, "after_abort");
    chk("after_abort/result_lit", 32'(result_o), 32'h02);
    tick();

    // Back-to-back: start accepted in the done cycle.
    launch(8'h9C, 8'h47, 1'b1);
    wait_check(8'h9C, 8'h47, 1'b1, "b2b_first");
    launch(8'h6E, 8'hA1, 1'b0);
    wait_check(8'h6E, 8'hA1, 1'b0, "b2b_second");
    tick();
    chk("b2b/idle_busy", 32'(busy_o), 32'd0);

    // Randomized operations, some chained back-to-back.
    for (int i = 0; i < 24; i++) begin
      ra = N'($urandom); rb = N'($urandom); rm = 1'($urandom);
      launch(ra, rb, rm);
      wait_check(ra, rb, rm, $sformatf("rand%0d", i));
      if ($urandom_range(1, 0) == 0) tick();
    end
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
